multi_bank_buffer: RTL
======================

// Module: multi_bank_buffer
// PURPOSE
//  Single-clock, parametrised successor to the 2-bank ping-pong store between producers (row_drawer, entities_drawer) and consumers.
//  Holds BANKS banks of 2**A words x S bits. BANKS=3 gives triple buffering: the producer commits finished frames and the consumer swaps at its boundary, with no tearing or stall.
//  BANKS=2 keeps legacy swap-only behaviour. Optional hardware clear of each newly assigned write bank.
// PARAMETERS
//  A            9    address width; bank depth = 2**A
//  S            24   data width
//  BANKS        3    2 (legacy ping-pong) or 3 (triple buffer); other values are illegal and fail elaboration
//  CLEAR_EN     0    1: fill each new write bank with CLEAR_VAL after assignment
//  CLEAR_VAL    0    S-bit clear word
// PORTS
//  clock          in   1   sole clock, rising edge
//  reset_reset_n  in   1   asynchronous, active-low reset
//  wr_address     in   A   producer write address
//  wr_data        in   S   producer write data
//  wren           in   1   write strobe
//  wr_commit      in   1   1-cycle pulse: write bank complete (ignored when BANKS=2)
//  rd_address     in   A   consumer read address
//  rd_data        out  S   read data, 1-cycle latency
//  rd_swap        in   1   1-cycle pulse: consumer frame/row boundary
//  wr_bank        out  2   bank currently written
//  rd_bank        out  2   bank currently read
//  frame_ready    out  1   a committed, unread bank is pending (BANKS=3)
//  dropped        out  1   1-cycle pulse: a pending frame was overwritten unread
//  repeated       out  1   1-cycle pulse: rd_swap arrived with nothing pending
//  clear_busy     out  1   clear sweep in progress; wren ignored while high
// BEHAVIOUR
//  Reset (async assert, sync release): wr_bank=0, rd_bank=1, pend_bank=2, frame_ready=0, dropped=0, repeated=0, rd_data=0.
//   clear_busy=0; no clear runs at reset. Memory contents are undefined.
//  Write: when wren=1 and clear_busy=0, mem[wr_bank][wr_address] <= wr_data.
//   A write in a switch cycle uses the pre-switch wr_bank.
//  Read: rd_address and rd_bank are sampled at edge N; rd_data is valid after edge N+1.
//   A read in a swap cycle uses the pre-swap rd_bank.
//  BANKS=2: rd_swap exchanges wr_bank and rd_bank. wr_commit, frame_ready, dropped and repeated stay 0.
//  BANKS=3: the bank roles {W,R,P} are always a permutation of {0,1,2}.
//   commit only: P<=W, W<=P, frame_ready<=1; dropped=1 if frame_ready was already 1.
//   swap only, frame_ready=1: R<=P, P<=R, frame_ready<=0.
//   swap only, frame_ready=0: no change; repeated=1.
//   commit+swap together: R<=W, W<=R, P unchanged; frame_ready<=0.
//    dropped=1 if frame_ready was 1, because the newest frame wins.
//  Clear FSM (CLEAR_EN=1): IDLE -> CLEAR on any change of wr_bank.
//   CLEAR writes CLEAR_VAL at counter 0..2**A-1, one word per cycle, then returns to IDLE. clear_busy=1 while in CLEAR.
//   A new W assignment during CLEAR restarts the counter at 0 on the new bank; the old bank is left partly cleared.
//   Reset during CLEAR returns to IDLE.
//  dropped and repeated are registered pulses, asserted in the cycle after the event edge.
// STRUCTURE
//  Shared include buffer_defs.vh: bank-index width (2), role reset encodings, clear FSM state codes.
//  One sub-module, sdp_ram_1clk #(AW,DW): single-clock simple-dual-port RAM with registered read.
//   It is instantiated BANKS times; the read mux selects on the registered rd_bank.
//  The top level holds the role registers, the permutation logic, the clear FSM and counter, and the write-enable decode.
// TESTING
//  1 Reset, BANKS=3: write 0xABCDEF@5, commit, swap, read @5.
//   -> rd_data=0xABCDEF one cycle later; rd_bank=0, wr_bank=2.
//  2 Two commits with no swap. -> dropped pulses once on the second commit;
//   the next swap reads the second frame's data; frame_ready=0.
//  3 Swap with frame_ready=0. -> repeated=1 for one cycle; rd_bank unchanged; the old data is read again.
//  4 commit+swap in the same cycle with frame_ready=0 -> R=old W, W=old R, dropped=0.
//   Repeat with frame_ready=1 -> dropped=1.
//  5 BANKS=2: 4 swaps with writes between them -> banks alternate 0/1; data follows the ping-pong; wr_commit has no effect.
//  6 CLEAR_EN=1, A=4, CLEAR_VAL=0x123: commit -> clear_busy high 16 cycles; the new bank reads 0x123 at all addresses.
//   Assert reset mid-clear -> clear_busy=0 immediately.

Source files
------------

// File: rtl/multi_bank_buffer_pkg.sv
// Shared definitions for the multi-bank frame buffer: bank index type,
// role reset encodings and clear sweep states.
package multi_bank_buffer_pkg;

    localparam int BANK_W = 2;

    typedef logic [BANK_W-1:0] bank_t;

    localparam bank_t WR_BANK_RST   = 2'd0;
    localparam bank_t RD_BANK_RST   = 2'd1;
    localparam bank_t PEND_BANK_RST = 2'd2;

    typedef enum logic {
        CLR_IDLE = 1'b0,
        CLR_RUN  = 1'b1
    } clr_state_t;

endpackage

// File: rtl/multi_bank_buffer_if.sv
// Producer/consumer bus of the multi-bank buffer. The master side is the
// producer/consumer pair, the slave side is the buffer itself.
interface multi_bank_buffer_if
    import multi_bank_buffer_pkg::*;
#(
    parameter int A = 9,
    parameter int S = 24
);
    logic [A-1:0] wr_address;
    logic [S-1:0] wr_data;
    logic         wren;
    logic         wr_commit;
    logic [A-1:0] rd_address;
    logic [S-1:0] rd_data;
    logic         rd_swap;
    bank_t        wr_bank;
    bank_t        rd_bank;
    logic         frame_ready;
    logic         dropped;
    logic         repeated;
    logic         clear_busy;

    modport master (
        output wr_address, wr_data, wren, wr_commit, rd_address, rd_swap,
        input  rd_data, wr_bank, rd_bank, frame_ready, dropped, repeated, clear_busy
    );

    modport slave (
        input  wr_address, wr_data, wren, wr_commit, rd_address, rd_swap,
        output rd_data, wr_bank, rd_bank, frame_ready, dropped, repeated, clear_busy
    );
endinterface

// File: rtl/multi_bank_buffer_ram.sv
// Single-clock simple-dual-port RAM with registered read port.
module sdp_ram_1clk #(
    parameter int AW = 9,
    parameter int DW = 24
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/multi_bank_buffer.sv
// Double/triple frame buffer: bank role registers, role permutation on
// commit/swap, optional clear sweep of each newly assigned write bank.
module multi_bank_buffer
    import multi_bank_buffer_pkg::*;
#(
    parameter int           A         = 9,
    parameter int           S         = 24,
    parameter int           BANKS     = 3,
    parameter int           CLEAR_EN  = 0,
    parameter logic [S-1:0] CLEAR_VAL = '0
) (
    input logic                clock,
    input logic                reset_reset_n,
    multi_bank_buffer_if.slave bus
);
    if (BANKS != 2 && BANKS != 3) begin : g_bad_banks
        $error("multi_bank_buffer: BANKS must be 2 or 3");
    end

    localparam logic [A-1:0] CNT_LAST = '1;

    bank_t      wr_bank, rd_bank, pend_bank;
    bank_t      wr_bank_nx, rd_bank_nx, pend_bank_nx;
    logic       frame_ready, frame_ready_nx;
    logic       dropped, dropped_nx;
    logic       repeated, repeated_nx;
    bank_t      rd_sel;
    logic       rd_live;
    clr_state_t clr_state;
    logic [A-1:0] clr_cnt;
    logic       clear_busy;

    logic [BANKS-1:0] ram_we;
    logic [A-1:0]     ram_waddr;
    logic [S-1:0]     ram_wdata;
    logic [S-1:0]     ram_q [BANKS];
    logic [S-1:0]     rd_mux;

    always_comb begin
        wr_bank_nx     = wr_bank;
        rd_bank_nx     = rd_bank;
        pend_bank_nx   = pend_bank;
        frame_ready_nx = frame_ready;
        dropped_nx     = 1'b0;
        repeated_nx    = 1'b0;
        if (BANKS == 2) begin
            if (bus.rd_swap) begin
                wr_bank_nx = rd_bank;
                rd_bank_nx = wr_bank;
            end
        end else begin
            case ({bus.wr_commit, bus.rd_swap})
                2'b10: begin
                    pend_bank_nx   = wr_bank;
                    wr_bank_nx     = pend_bank;
                    frame_ready_nx = 1'b1;
                    dropped_nx     = frame_ready;
                end
                2'b01: begin
                    if (frame_ready) begin
                        rd_bank_nx     = pend_bank;
                        pend_bank_nx   = rd_bank;
                        frame_ready_nx = 1'b0;
                    end else begin
                        repeated_nx = 1'b1;
                    end
                end
                // The frame just finished goes straight to the reader; any pending one is lost.
                2'b11: begin
                    rd_bank_nx     = wr_bank;
                    wr_bank_nx     = rd_bank;
                    frame_ready_nx = 1'b0;
                    dropped_nx     = frame_ready;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wr_bank     <= WR_BANK_RST;
            rd_bank     <= RD_BANK_RST;
            pend_bank   <= PEND_BANK_RST;
            frame_ready <= 1'b0;
            dropped     <= 1'b0;
            repeated    <= 1'b0;
            rd_sel      <= RD_BANK_RST;
            rd_live     <= 1'b0;
        end else begin
            wr_bank     <= wr_bank_nx;
            rd_bank     <= rd_bank_nx;
            pend_bank   <= pend_bank_nx;
            frame_ready <= frame_ready_nx;
            dropped     <= dropped_nx;
            repeated    <= repeated_nx;
            rd_sel      <= rd_bank;
            rd_live     <= 1'b1;
        end
    end

    // Any new write-bank assignment (re)starts the sweep from address 0.
    always_ff @(posedge clock or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            clr_state  <= CLR_IDLE;
            clr_cnt    <= '0;
            clear_busy <= 1'b0;
        end else if (CLEAR_EN != 0 && wr_bank_nx != wr_bank) begin
            clr_state  <= CLR_RUN;
            clr_cnt    <= '0;
            clear_busy <= 1'b1;
        end else if (clr_state == CLR_RUN) begin
            if (clr_cnt == CNT_LAST) begin
                clr_state  <= CLR_IDLE;
                clear_busy <= 1'b0;
            end else begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        ram_waddr = bus.wr_address;
        ram_wdata = bus.wr_data;
        if (clear_busy) begin
            ram_waddr = clr_cnt;
            ram_wdata = CLEAR_VAL;
        end
        for (int b = 0; b < BANKS; b++) begin
            ram_we[b] = (wr_bank == bank_t'(b)) && (clear_busy || bus.wren);
        end
    end

    for (genvar g = 0; g < BANKS; g++) begin : g_bank
        sdp_ram_1clk #(.AW(A), .DW(S)) u_ram (
            .clk   (clock),
            .we    (ram_we[g]),
            .waddr (ram_waddr),
            .wdata (ram_wdata),
            .raddr (bus.rd_address),
            .rdata (ram_q[g])
        );
    end

    always_comb begin
        rd_mux = '0;
        for (int b = 0; b < BANKS; b++) begin
            if (rd_sel == bank_t'(b)) rd_mux = ram_q[b];
        end
    end

    assign bus.rd_data     = rd_live ? rd_mux : '0;
    assign bus.wr_bank     = wr_bank;
    assign bus.rd_bank     = rd_bank;
    assign bus.frame_ready = frame_ready;
    assign bus.dropped     = dropped;
    assign bus.repeated    = repeated;
    assign bus.clear_busy  = clear_busy;
endmodule
